// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter that shares one memory port between NUM_REQ
//   requesters. It supports per-requester lock with a bounded run length and
//   a one-cycle read return.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   req          per-requester access request
//   we           per-requester write (1) / read (0) select
//   lock         per-requester request to keep the grant next cycle
//   addr, wdata  flattened per-requester address / write data
//                (requester i at [i*W +: W])
//   gnt          one-hot grant, combinational, same cycle as req
//   rdata        read data shared by all requesters (passes r_data through)
//   rvalid       one-hot qualifier for rdata, one cycle after the read grant
//   w_en, w_addr, w_data   memory write port
//   r_addr, r_data         memory read port (r_data valid one cycle after r_addr)
module mem_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16,
  parameter int LOCK_MAX  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [WORD_SIZE-1:0]           rdata,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic                           w_en,
  output logic [ADDR_SIZE-1:0]           w_addr,
  output logic [WORD_SIZE-1:0]           w_data,
  output logic [ADDR_SIZE-1:0]           r_addr,
  input  logic [WORD_SIZE-1:0]           r_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     lock_idx, lock_idx_nxt;
  logic                 lock_valid, lock_valid_nxt;
  logic [CNT_W-1:0]     lock_cnt, lock_cnt_nxt;
  logic [NUM_REQ-1:0]   rd_tag;
  logic [ADDR_SIZE-1:0] r_addr_q;

  logic [PTR_W-1:0]     gnt_idx;
  logic                 any_gnt;
  logic                 holder_req, locked, forced;
  logic                 wr_gnt, rd_gnt;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  int unsigned          rr_idx;

  // Arbitration: a live lock holder below its run limit wins outright.
  // Otherwise search round-robin starting just after the last winner.
  always_comb begin
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    rr_idx     = 0;
    holder_req = lock_valid && req[lock_idx];
    locked     = holder_req && (lock_cnt < CNT_W'(LOCK_MAX));
    forced     = holder_req && !locked;
    if (locked) begin
      gnt_idx = lock_idx;
      any_gnt = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        rr_idx = (32'(ptr) + k) % NUM_REQ;
        if (!any_gnt && req[PTR_W'(rr_idx)]) begin
          gnt_idx = PTR_W'(rr_idx);
          any_gnt = 1'b1;
        end
      end
    end
    // No grant may leave the block while reset is held.
    if (!rst_n) begin
      any_gnt = 1'b0;
    end
  end

  always_comb begin
    sel_addr  = addr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
    sel_wdata = wdata[gnt_idx*WORD_SIZE +: WORD_SIZE];
    wr_gnt    = any_gnt && we[gnt_idx];
    rd_gnt    = any_gnt && !we[gnt_idx];
    gnt       = any_gnt ? (NUM_REQ'(1) << gnt_idx) : '0;
    w_en      = wr_gnt;
    w_addr    = wr_gnt ? sel_addr  : '0;
    w_data    = wr_gnt ? sel_wdata : '0;
    // The read address is presented in the grant cycle so that a synchronous
    // memory returns data in the following cycle. Between reads it holds.
    r_addr    = rd_gnt ? sel_addr : r_addr_q;
    rvalid    = rd_tag;
    rdata     = r_data;
  end

  // Lock bookkeeping. lock_cnt is the number of consecutive grants already
  // given to the holder. On hitting LOCK_MAX the holder sits out exactly one
  // round-robin arbitration but keeps ownership of the lock. If the holder
  // drops req, the lock is released.
  always_comb begin
    lock_valid_nxt = 1'b0;
    lock_idx_nxt   = lock_idx;
    lock_cnt_nxt   = '0;
    if (any_gnt) begin
      if (lock[gnt_idx]) begin
        lock_valid_nxt = 1'b1;
        lock_idx_nxt   = gnt_idx;
        lock_cnt_nxt   = locked ? lock_cnt + 1'b1 : CNT_W'(1);
      end else if (forced && (gnt_idx != lock_idx)) begin
        lock_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= PTR_W'(NUM_REQ - 1);
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      lock_cnt   <= '0;
      rd_tag     <= '0;
      r_addr_q   <= '0;
    end else begin
      if (any_gnt) begin
        ptr <= gnt_idx;
      end
      lock_valid <= lock_valid_nxt;
      lock_idx   <= lock_idx_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rd_tag     <= rd_gnt ? gnt : '0;
      r_addr_q   <= r_addr;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we, lock;
  logic [29:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, w_data, r_data;
  logic        w_en;
  logic [9:0]  w_addr, r_addr;

  int tests  = 0;
  int failed = 0;

  // Synchronous memory: contents default to 0xA000|addr (0x5555 at addr 5)
  // until written.
  logic [15:0]   wmem [0:1023];
  logic [1023:0] written = '0;

  mem_port_arbiter #(
    .NUM_REQ  (3),
    .ADDR_SIZE(10),
    .WORD_SIZE(16),
    .LOCK_MAX (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .lock  (lock),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .rdata (rdata),
    .rvalid(rvalid),
    .w_en  (w_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .r_addr(r_addr),
    .r_data(r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en) begin
      wmem[w_addr]    <= w_data;
      written[w_addr] <= 1'b1;
    end
    if (written[r_addr])
      r_data <= wmem[r_addr];
    else if (r_addr == 10'd5)
      r_data <= 16'h5555;
    else
      r_data <= 16'hA000 | {6'd0, r_addr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pa(input logic [9:0] a2, input logic [9:0] a1,
                                     input logic [9:0] a0);
    return {a2, a1, a0};
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic apply(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                       input logic [29:0] a, input logic [47:0] d);
    @(negedge clk);
    req = r; we = w; lock = l; addr = a; wdata = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 3'b111; we = 3'b000; lock = 3'b000;
    addr = pa(10'd3, 10'd2, 10'd1); wdata = '0;
    #2;
    chk("rst_gnt",    gnt,    3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_w_en",   w_en,   1'b0);
    chk("rst_r_addr", r_addr, 10'd0);
    chk("rst_w_addr", w_addr, 10'd0);
    chk("rst_w_data", w_data, 16'd0);

    // Round-robin reads from all three requesters.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr1_gnt",    gnt,    3'b001);
    chk("rr1_raddr",  r_addr, 10'd1);
    chk("rr1_rvalid", rvalid, 3'b000);
    apply(3'b111, 3'b000, 3'b000, pa(10'd3, 10'd2, 10'd1), '0);
    chk("rr2_gnt",    gnt,    3'b010);
    chk("rr2_raddr",  r_addr, 10'd2);
    chk("rr2_rvalid", rvalid, 3'b001);
    chk("rr2_rdata",  rdata,  16'hA001);
    apply(3'b111, 3'b000, 3'b000, pa(10'd3, 10'd2, 10'd1), '0);
    chk("rr3_gnt",    gnt,    3'b100);
    chk("rr3_raddr",  r_addr, 10'd3);
    chk("rr3_rvalid", rvalid, 3'b010);
    chk("rr3_rdata",  rdata,  16'hA002);
    apply(3'b111, 3'b000, 3'b000, pa(10'd3, 10'd2, 10'd1), '0);
    chk("rr4_gnt",    gnt,    3'b001);
    chk("rr4_rvalid", rvalid, 3'b100);
    chk("rr4_rdata",  rdata,  16'hA003);

    // Write by requester 0; r_addr holds the last read address.
    apply(3'b001, 3'b001, 3'b000, pa(10'd0, 10'd0, 10'h003), {32'd0, 16'h0012});
    chk("wr_gnt",    gnt,    3'b001);
    chk("wr_w_en",   w_en,   1'b1);
    chk("wr_w_addr", w_addr, 10'h003);
    chk("wr_w_data", w_data, 16'h0012);
    chk("wr_raddr",  r_addr, 10'd1);
    chk("wr_rvalid", rvalid, 3'b001);
    apply(3'b000, 3'b000, 3'b000, '0, '0);
    chk("idle_gnt",    gnt,    3'b000);
    chk("idle_rvalid", rvalid, 3'b000);
    chk("idle_w_en",   w_en,   1'b0);

    // Back-to-back read then write from requester 2, then read-back.
    apply(3'b100, 3'b000, 3'b000, pa(10'h005, 10'd0, 10'd0), '0);
    chk("b2b_rd_gnt",   gnt,    3'b100);
    chk("b2b_rd_raddr", r_addr, 10'h005);
    apply(3'b100, 3'b100, 3'b000, pa(10'h007, 10'd0, 10'd0), {16'hBEEF, 32'd0});
    chk("b2b_wr_gnt",   gnt,    3'b100);
    chk("b2b_wr_w_en",  w_en,   1'b1);
    chk("b2b_wr_waddr", w_addr, 10'h007);
    chk("b2b_rvalid",   rvalid, 3'b100);
    chk("b2b_rdata",    rdata,  16'h5555);
    chk("b2b_raddr",    r_addr, 10'h005);
    apply(3'b001, 3'b000, 3'b000, pa(10'd0, 10'd0, 10'h007), '0);
    chk("rb_gnt",    gnt,    3'b001);
    chk("rb_rvalid", rvalid, 3'b000);
    apply(3'b000, 3'b000, 3'b000, '0, '0);
    chk("rb_rvalid2", rvalid, 3'b001);
    chk("rb_rdata",   rdata,  16'hBEEF);

    // Requester 1 locks with all requesting: 16 grants, one forced to 2, back to 1.
    for (int i = 0; i < 20; i++) begin
      apply(3'b111, 3'b000, 3'b010, pa(10'd3, 10'd2, 10'd1), '0);
      chk($sformatf("lock%0d_gnt", i), gnt, (i == 16) ? 3'b100 : 3'b010);
    end

    // Holder drops req: same-cycle round-robin, lock released afterwards.
    apply(3'b101, 3'b000, 3'b010, pa(10'd3, 10'd2, 10'd1), '0);
    chk("drop_gnt", gnt, 3'b100);
    apply(3'b111, 3'b000, 3'b000, pa(10'd3, 10'd2, 10'd1), '0);
    chk("drop_next_gnt", gnt, 3'b001);

    // Reset just before the edge ending a read grant suppresses rvalid.
    apply(3'b010, 3'b000, 3'b000, pa(10'd3, 10'd2, 10'd1), '0);
    chk("mrst_gnt", gnt, 3'b010);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_rvalid", rvalid, 3'b000);
    chk("mrst_gnt0",   gnt,    3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b111; we = 3'b000; lock = 3'b000; addr = pa(10'd3, 10'd2, 10'd1);
    #1;
    chk("mrst_restart_gnt", gnt, 3'b001);
    apply(3'b000, 3'b000, 3'b000, '0, '0);
    chk("mrst_rvalid2", rvalid, 3'b001);
    chk("mrst_rdata",   rdata,  16'hA001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of requesters (0 = host loader, 1 = result writeback, 2 = host readback).
REQ-002 The block SHALL have parameter ADDR_SIZE, default 10, giving the memory address width.
REQ-003 The block SHALL have parameter WORD_SIZE, default 16, giving the memory data width.
REQ-004 The block SHALL have parameter LOCK_MAX, default 16, giving the maximum number of consecutive locked grants.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req, input, NUM_REQ bits: per-requester access request.
REQ-008 The block SHALL have port we, input, NUM_REQ bits: per-requester write (1) or read (0) select.
REQ-009 The block SHALL have port lock, input, NUM_REQ bits: per-requester request to keep the grant next cycle.
REQ-010 The block SHALL have port addr, input, NUM_REQ*ADDR_SIZE bits: flattened addresses, requester i at slice [i*ADDR_SIZE +: ADDR_SIZE].
REQ-011 The block SHALL have port wdata, input, NUM_REQ*WORD_SIZE bits: flattened write data, same slicing rule.
REQ-012 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant, combinational, valid in the same cycle as req.
REQ-013 The block SHALL have port rdata, output, WORD_SIZE bits: read data shared by all requesters.
REQ-014 The block SHALL have port rvalid, output, NUM_REQ bits: one-hot pulse qualifying rdata for the owning requester.
REQ-015 The block SHALL have port w_en, output, 1 bit: memory write enable.
REQ-016 The block SHALL have port w_addr, output, ADDR_SIZE bits: memory write address.
REQ-017 The block SHALL have port w_data, output, WORD_SIZE bits: memory write data.
REQ-018 The block SHALL have port r_addr, output, ADDR_SIZE bits: memory read address.
REQ-019 The block SHALL have port r_data, input, WORD_SIZE bits: memory read data, valid one cycle after r_addr.

Function
REQ-020 The block SHALL grant at most one requester per cycle; gnt SHALL be 0 when req is 0.
REQ-021 The block SHALL arbitrate round-robin: the search starts at index ptr+1 modulo NUM_REQ and grants the first requester with req set; ptr holds the index of the last granted requester.
REQ-022 On every cycle with any grant, ptr SHALL update to the granted index.
REQ-023 The block SHALL handle a transfer as complete in the cycle gnt[i] and req[i] are both 1; requesters drop req or present the next access the following cycle.
REQ-024 For the granted requester with we=1, the block SHALL drive w_en=1, w_addr=its addr and w_data=its wdata; otherwise w_en SHALL be 0.
REQ-025 For the granted requester with we=0, the block SHALL drive r_addr=its addr; otherwise r_addr SHALL hold its previous value.
REQ-026 For a read granted in cycle N, the block SHALL drive rvalid[i]=1 and rdata=r_data in cycle N+1 only, with a registered one-hot tag, giving a read latency of 1.
REQ-027 rdata SHALL be driven directly from r_data, with no additional register.
REQ-028 Lock: if the granted requester has lock=1, the block SHALL bypass round-robin next cycle and grant that requester alone while its req=1.
REQ-029 Lock: a lock counter SHALL count consecutive locked grants; when it reaches LOCK_MAX, the lock SHALL be ignored for one arbitration, forcing round-robin.
REQ-030 Lock: the lock counter SHALL clear whenever the grant moves or req of the lock holder drops.
REQ-031 If the lock holder drops req, the block SHALL release the lock and perform normal round-robin arbitration in the same cycle.
REQ-032 Starvation bound: with no locks, a requester holding req SHALL be granted within NUM_REQ cycles.
REQ-033 A back-to-back read then write by the same or different requesters SHALL be allowed in consecutive cycles without stalls.

Reset
REQ-034 While rst_n=0, the outputs SHALL be: gnt=0, rvalid=0, w_en=0, r_addr=0, w_addr=0, w_data=0.
REQ-035 While rst_n=0, the internal state SHALL be: ptr=NUM_REQ-1 (so requester 0 wins first), lock state cleared, lock counter=0, read tag=0.
REQ-036 Reset asserted mid-read SHALL suppress the pending rvalid pulse.
REQ-037 The first arbitration SHALL occur in the first clock edge after rst_n deasserts.

Verification
REQ-038 Scenario: after reset, req=3'b111 held with we=0 -> gnt sequence 001, 010, 100, 001; each rvalid follows its grant by 1 cycle.
REQ-039 Scenario: req[0] write addr=0x003 data=0x0012 -> w_en=1, w_addr=0x003, w_data=0x0012 same cycle; no rvalid.
REQ-040 Scenario: requester 1 lock=1 with req=3'b111 for 20 cycles, LOCK_MAX=16 -> gnt=010 for 16 consecutive cycles, then one cycle to requester 2, then back to 010.
REQ-041 Scenario: requester 2 reads addr 0x005 where memory holds 0x5555 -> rvalid=100, rdata=0x5555 next cycle.
REQ-042 Scenario: rst_n pulsed low in the cycle after a read grant -> rvalid stays 0 and ptr restarts at requester 0.
REQ-043 Scenario: requester 1 locked, then drops req while req[2]=1 -> gnt=100 in the same cycle, lock counter=0.
